// File: rtl/alu_defs_pkg.sv
// Shared ALU definitions: op codes, MIPS opcode/funct encodings, decoded control struct.
// Pure definitions; no logic, no latency.
// No flow control; consumed by the decoder and the ID/EX stage.
package alu_defs_pkg;

  // ALU op codes seen by the EX-side ALU
  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_SRA = 4'b0110;
  localparam logic [3:0] ALU_NOR = 4'b0111;
  localparam logic [3:0] ALU_SLT = 4'b1000;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // Decoded control for one instruction.
  //   sel_shift : in1 takes rt instead of rs (shift source lives in rt)
  //   sel_imm   : in2 takes the extended immediate instead of rt
  //   imm_zext  : logical immediates are zero-extended, others sign-extended
  //   dst_rd    : destination is rd (R-type) rather than rt (I-type)
  typedef struct packed {
    logic [3:0] op;
    logic [4:0] shamt;
    logic       sel_shift;
    logic       sel_imm;
    logic       imm_zext;
    logic       dst_rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       illegal;
  } alu_ctrl_t;

  // Illegal-instruction marker: every other field cleared so nothing leaks
  // into EX from an undecodable word.
  function automatic alu_ctrl_t ctrl_illegal();
    alu_ctrl_t c;
    c         = '0;
    c.illegal = 1'b1;
    return c;
  endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Combinational MIPS instruction-field decoder producing ALU control and destination index.
// Latency: zero (pure combinational).
// No flow control; output follows the input fields every cycle.
module alu_op_decode
  import alu_defs_pkg::*;
(
  input  logic [5:0] i_opcode,
  input  logic [4:0] i_rt,
  input  logic [4:0] i_rd,
  input  logic [4:0] i_shamt,
  input  logic [5:0] i_funct,
  output alu_ctrl_t  o_ctrl,
  output logic [4:0] o_dst
);

  alu_ctrl_t  w_ctrl;
  logic [4:0] w_dst;

  // Decode opcode/funct into control, then suppress writes to $zero
  always_comb begin
    w_ctrl = '0;
    w_dst  = '0;
    case (i_opcode)
      OPC_RTYPE: begin
        w_ctrl.dst_rd    = 1'b1;
        w_ctrl.reg_write = 1'b1;
        case (i_funct)
          FN_ADD, FN_ADDU: w_ctrl.op = ALU_ADD;
          FN_SUB, FN_SUBU: w_ctrl.op = ALU_SUB;
          FN_AND:          w_ctrl.op = ALU_AND;
          FN_OR:           w_ctrl.op = ALU_OR;
          FN_NOR:          w_ctrl.op = ALU_NOR;
          FN_SLT:          w_ctrl.op = ALU_SLT;
          FN_SLL: begin
            w_ctrl.op        = ALU_SLL;
            w_ctrl.sel_shift = 1'b1;
            w_ctrl.shamt     = i_shamt;
          end
          FN_SRL: begin
            w_ctrl.op        = ALU_SRL;
            w_ctrl.sel_shift = 1'b1;
            w_ctrl.shamt     = i_shamt;
          end
          FN_SRA: begin
            w_ctrl.op        = ALU_SRA;
            w_ctrl.sel_shift = 1'b1;
            w_ctrl.shamt     = i_shamt;
          end
          default: w_ctrl.illegal = 1'b1;
        endcase
      end
      OPC_ADDI, OPC_ADDIU: begin
        w_ctrl.op        = ALU_ADD;
        w_ctrl.sel_imm   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OPC_SLTI: begin
        w_ctrl.op        = ALU_SLT;
        w_ctrl.sel_imm   = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OPC_ANDI: begin
        w_ctrl.op        = ALU_AND;
        w_ctrl.sel_imm   = 1'b1;
        w_ctrl.imm_zext  = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OPC_ORI: begin
        w_ctrl.op        = ALU_OR;
        w_ctrl.sel_imm   = 1'b1;
        w_ctrl.imm_zext  = 1'b1;
        w_ctrl.reg_write = 1'b1;
      end
      OPC_LW: begin
        w_ctrl.op        = ALU_ADD;
        w_ctrl.sel_imm   = 1'b1;
        w_ctrl.reg_write = 1'b1;
        w_ctrl.mem_read  = 1'b1;
      end
      OPC_SW: begin
        w_ctrl.op        = ALU_ADD;
        w_ctrl.sel_imm   = 1'b1;
        w_ctrl.mem_write = 1'b1;
      end
      OPC_BEQ: begin
        // EX resolves the branch by subtracting rt from rs
        w_ctrl.op     = ALU_SUB;
        w_ctrl.branch = 1'b1;
      end
      default: w_ctrl.illegal = 1'b1;
    endcase

    if (w_ctrl.illegal) begin
      w_ctrl = ctrl_illegal();
    end

    w_dst = w_ctrl.dst_rd ? i_rd : i_rt;

    // $zero is hardwired; a write to it is dropped here rather than in WB
    if (w_dst == 5'd0) begin
      w_ctrl.reg_write = 1'b0;
    end
  end

  assign o_ctrl = w_ctrl;
  assign o_dst  = w_dst;

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX stage: decodes the ID instruction, muxes/extends ALU operands and registers them for EX.
// Latency: 1 cycle ID -> EX outputs.
// Backpressure: stall holds the ID/EX register (id_ready = ~stall); flush inserts a bubble and beats stall.
module alu_issue_stage
  import alu_defs_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic              stall,
  input  logic              flush,
  output logic              id_ready,
  output logic              ex_valid,
  output logic [3:0]        ex_op,
  output logic [4:0]        ex_shamt,
  output logic [DATA_W-1:0] ex_in1,
  output logic [DATA_W-1:0] ex_in2,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [REG_AW-1:0] ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_branch,
  output logic              ex_illegal
);

  alu_ctrl_t         w_ctrl;
  logic [4:0]        w_dst5;
  logic [15:0]       w_imm;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_in1;
  logic [DATA_W-1:0] w_in2;
  logic              w_load_ok;
  logic              w_unused_rs_idx;

  // Load-side next values (bubble unless a legal, valid instruction is in ID)
  logic              w_ld_valid;
  logic [3:0]        w_ld_op;
  logic [4:0]        w_ld_shamt;
  logic [DATA_W-1:0] w_ld_in1;
  logic [DATA_W-1:0] w_ld_in2;
  logic [DATA_W-1:0] w_ld_rt_data;
  logic [REG_AW-1:0] w_ld_dst;
  logic              w_ld_reg_write;
  logic              w_ld_mem_read;
  logic              w_ld_mem_write;
  logic              w_ld_branch;
  logic              w_ld_illegal;

  logic              r_valid;
  logic [3:0]        r_op;
  logic [4:0]        r_shamt;
  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;
  logic [DATA_W-1:0] r_rt_data;
  logic [REG_AW-1:0] r_dst;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_branch;
  logic              r_illegal;

  // rs arrives as already-forwarded data, so its index field is not needed here
  assign w_unused_rs_idx = ^id_instr[25:21];

  alu_op_decode u_decode (
    .i_opcode (id_instr[31:26]),
    .i_rt     (id_instr[20:16]),
    .i_rd     (id_instr[15:11]),
    .i_shamt  (id_instr[10:6]),
    .i_funct  (id_instr[5:0]),
    .o_ctrl   (w_ctrl),
    .o_dst    (w_dst5)
  );

  assign w_imm     = id_instr[15:0];
  assign w_imm_ext = w_ctrl.imm_zext ? {{(DATA_W-16){1'b0}}, w_imm}
                                     : {{(DATA_W-16){w_imm[15]}}, w_imm};

  // Shifts take their source from rt on both ALU inputs; otherwise rs feeds in1
  assign w_in1 = w_ctrl.sel_shift ? id_rt_data : id_rs_data;
  assign w_in2 = w_ctrl.sel_imm   ? w_imm_ext  : id_rt_data;

  assign w_load_ok = id_valid & ~w_ctrl.illegal;

  // Build the value the register takes on a normal load cycle
  always_comb begin
    w_ld_valid     = 1'b0;
    w_ld_op        = ALU_ADD;
    w_ld_shamt     = '0;
    w_ld_in1       = '0;
    w_ld_in2       = '0;
    w_ld_rt_data   = '0;
    w_ld_dst       = '0;
    w_ld_reg_write = 1'b0;
    w_ld_mem_read  = 1'b0;
    w_ld_mem_write = 1'b0;
    w_ld_branch    = 1'b0;
    w_ld_illegal   = id_valid & w_ctrl.illegal;
    if (w_load_ok) begin
      w_ld_valid     = 1'b1;
      w_ld_op        = w_ctrl.op;
      w_ld_shamt     = w_ctrl.shamt;
      w_ld_in1       = w_in1;
      w_ld_in2       = w_in2;
      w_ld_rt_data   = id_rt_data;
      w_ld_dst       = REG_AW'(w_dst5);
      w_ld_reg_write = w_ctrl.reg_write;
      w_ld_mem_read  = w_ctrl.mem_read;
      w_ld_mem_write = w_ctrl.mem_write;
      w_ld_branch    = w_ctrl.branch;
    end
  end

  // ID/EX register: reset and flush both clear, stall holds (illegal pulse drops), else load
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_valid     <= 1'b0;
      r_op        <= ALU_ADD;
      r_shamt     <= '0;
      r_in1       <= '0;
      r_in2       <= '0;
      r_rt_data   <= '0;
      r_dst       <= '0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (stall) begin
      r_illegal   <= 1'b0;
    end else begin
      r_valid     <= w_ld_valid;
      r_op        <= w_ld_op;
      r_shamt     <= w_ld_shamt;
      r_in1       <= w_ld_in1;
      r_in2       <= w_ld_in2;
      r_rt_data   <= w_ld_rt_data;
      r_dst       <= w_ld_dst;
      r_reg_write <= w_ld_reg_write;
      r_mem_read  <= w_ld_mem_read;
      r_mem_write <= w_ld_mem_write;
      r_branch    <= w_ld_branch;
      r_illegal   <= w_ld_illegal;
    end
  end

  assign id_ready     = ~stall;
  assign ex_valid     = r_valid;
  assign ex_op        = r_op;
  assign ex_shamt     = r_shamt;
  assign ex_in1       = r_in1;
  assign ex_in2       = r_in2;
  assign ex_rt_data   = r_rt_data;
  assign ex_dst       = r_dst;
  assign ex_reg_write = r_reg_write;
  assign ex_mem_read  = r_mem_read;
  assign ex_mem_write = r_mem_write;
  assign ex_branch    = r_branch;
  assign ex_illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: directed cases then randomized traffic vs a reference model.
// Checks every EX output one cycle after each applied ID vector.
// Exercises stall hold, flush bubbles, flush+stall, reset mid-stall and illegal pulses.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst, id_valid, stall, flush;
  logic [31:0] id_instr, id_rs_data, id_rt_data;
  logic        id_ready, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal;
  logic [3:0]  ex_op;
  logic [4:0]  ex_shamt, ex_dst;
  logic [31:0] ex_in1, ex_in2, ex_rt_data;

  int n_vec = 0;
  int n_err = 0;

  // Expected EX state; *_known flags mark fields whose value is defined
  logic        e_valid, e_ill, e_rw, e_mr, e_mw, e_br;
  logic [3:0]  e_op;
  logic [4:0]  e_sh, e_dst;
  logic [31:0] e_in1, e_in2, e_rtd;
  logic        e_data_known, e_rtd_known;

  always #5 clk = ~clk;

  alu_issue_stage #(.DATA_W(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .stall(stall), .flush(flush),
    .id_ready(id_ready), .ex_valid(ex_valid), .ex_op(ex_op), .ex_shamt(ex_shamt),
    .ex_in1(ex_in1), .ex_in2(ex_in2), .ex_rt_data(ex_rt_data), .ex_dst(ex_dst),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_enc(input int rs, rt, rd, sh, input logic [5:0] fn);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), fn};
  endfunction

  function automatic logic [31:0] i_enc(input logic [5:0] opc, input int rs, rt, input logic [15:0] imm);
    return {opc, 5'(rs), 5'(rt), imm};
  endfunction

  // Reference: what a MIPS ALU-issue stage must send to EX for one instruction
  task automatic ref_decode(input logic [31:0] ins, input logic [31:0] rs, rt,
                            output bit legal, output logic [3:0] op, output logic [4:0] sh,
                            output logic [31:0] in1, in2, output logic [4:0] dst,
                            output logic rw, mr, mw, br);
    logic [31:0] sext, zext;
    sext  = {{16{ins[15]}}, ins[15:0]};
    zext  = {16'h0000, ins[15:0]};
    legal = 1; op = 0; sh = 0; in1 = rs; in2 = rt; rw = 0; mr = 0; mw = 0; br = 0;
    if (ins[31:26] == 6'h00) begin
      dst = ins[15:11]; rw = 1;
      case (ins[5:0])
        6'h20, 6'h21: op = 0;
        6'h22, 6'h23: op = 1;
        6'h24: op = 2;
        6'h25: op = 3;
        6'h27: op = 7;
        6'h2A: op = 8;
        6'h00: begin op = 4; sh = ins[10:6]; in1 = rt; end
        6'h02: begin op = 5; sh = ins[10:6]; in1 = rt; end
        6'h03: begin op = 6; sh = ins[10:6]; in1 = rt; end
        default: legal = 0;
      endcase
    end else begin
      dst = ins[20:16];
      case (ins[31:26])
        6'h08, 6'h09: begin op = 0; in2 = sext; rw = 1; end
        6'h0A: begin op = 8; in2 = sext; rw = 1; end
        6'h0C: begin op = 2; in2 = zext; rw = 1; end
        6'h0D: begin op = 3; in2 = zext; rw = 1; end
        6'h23: begin op = 0; in2 = sext; rw = 1; mr = 1; end
        6'h2B: begin op = 0; in2 = sext; mw = 1; end
        6'h04: begin op = 1; br = 1; end
        default: legal = 0;
      endcase
    end
    if (dst == 0) rw = 0;
  endtask

  task automatic model_next(input logic r, v, s, f, input logic [31:0] ins, rsd, rtd);
    bit legal;
    logic [3:0] op; logic [4:0] sh, dst; logic [31:0] in1, in2; logic rw, mr, mw, br;
    if (r || f) begin
      {e_valid, e_ill, e_rw, e_mr, e_mw, e_br} = '0;
      e_op = 0; e_sh = 0; e_dst = 0; e_in1 = 0; e_in2 = 0; e_rtd = 0;
      e_data_known = 1; e_rtd_known = 1;
    end else if (s) begin
      e_ill = 0;
    end else begin
      {e_valid, e_ill, e_rw, e_mr, e_mw, e_br} = '0;
      e_data_known = 0; e_rtd_known = 0;
      if (v) begin
        ref_decode(ins, rsd, rtd, legal, op, sh, in1, in2, dst, rw, mr, mw, br);
        if (!legal) e_ill = 1;
        else begin
          e_valid = 1; e_op = op; e_sh = sh; e_in1 = in1; e_in2 = in2; e_dst = dst;
          e_rw = rw; e_mr = mr; e_mw = mw; e_br = br; e_rtd = rtd;
          e_data_known = 1; e_rtd_known = mw;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("ex_valid", ex_valid, e_valid);
    chk("ex_illegal", ex_illegal, e_ill);
    chk("ex_reg_write", ex_reg_write, e_rw);
    chk("ex_mem_read", ex_mem_read, e_mr);
    chk("ex_mem_write", ex_mem_write, e_mw);
    chk("ex_branch", ex_branch, e_br);
    if (e_data_known) begin
      chk("ex_op", ex_op, e_op);
      chk("ex_shamt", ex_shamt, e_sh);
      chk("ex_in1", ex_in1, e_in1);
      chk("ex_in2", ex_in2, e_in2);
      chk("ex_dst", ex_dst, e_dst);
    end
    if (e_rtd_known) chk("ex_rt_data", ex_rt_data, e_rtd);
  endtask

  // Apply one ID-side vector, check id_ready, clock it, check EX outputs
  task automatic step(input logic r, v, s, f, input logic [31:0] ins, rsd, rtd);
    logic exp_rdy;
    rst = r; id_valid = v; stall = s; flush = f;
    id_instr = ins; id_rs_data = rsd; id_rt_data = rtd;
    exp_rdy = ~s;
    #1;
    chk("id_ready", id_ready, exp_rdy);
    model_next(r, v, s, f, ins, rsd, rtd);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  function automatic logic [31:0] rand_instr();
    int rs, rt, rd, sh;
    logic [15:0] imm;
    rs = $urandom_range(0, 7); rt = $urandom_range(0, 7); rd = $urandom_range(0, 7);
    sh = $urandom_range(0, 31); imm = 16'($urandom);
    case ($urandom_range(0, 21))
      0: return r_enc(rs, rt, rd, sh, 6'h20);
      1: return r_enc(rs, rt, rd, sh, 6'h21);
      2: return r_enc(rs, rt, rd, sh, 6'h22);
      3: return r_enc(rs, rt, rd, sh, 6'h23);
      4: return r_enc(rs, rt, rd, sh, 6'h24);
      5: return r_enc(rs, rt, rd, sh, 6'h25);
      6: return r_enc(rs, rt, rd, sh, 6'h27);
      7: return r_enc(rs, rt, rd, sh, 6'h2A);
      8: return r_enc(rs, rt, rd, sh, 6'h00);
      9: return r_enc(rs, rt, rd, sh, 6'h02);
      10: return r_enc(rs, rt, rd, sh, 6'h03);
      11: return i_enc(6'h08, rs, rt, imm);
      12: return i_enc(6'h09, rs, rt, imm);
      13: return i_enc(6'h0A, rs, rt, imm);
      14: return i_enc(6'h0C, rs, rt, imm);
      15: return i_enc(6'h0D, rs, rt, imm);
      16: return i_enc(6'h23, rs, rt, imm);
      17: return i_enc(6'h2B, rs, rt, imm);
      18: return i_enc(6'h04, rs, rt, imm);
      19: return r_enc(rs, rt, rd, sh, 6'h26);
      20: return i_enc(6'h3F, rs, rt, imm);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] lw_i, nxt_i, sw_i;
    rst = 1; id_valid = 0; stall = 0; flush = 0;
    id_instr = 0; id_rs_data = 0; id_rt_data = 0;

    // Reset, two cycles
    step(1, 0, 0, 0, 32'h0, 32'h0, 32'h0);
    step(1, 1, 0, 0, r_enc(1, 2, 3, 0, 6'h20), 32'd5, 32'd9);

    // add $3,$1,$2
    step(0, 1, 0, 0, r_enc(1, 2, 3, 0, 6'h20), 32'd5, 32'hFFFFFFF9);
    chk("add_in2_lit", ex_in2, 32'hFFFFFFF9);
    chk("add_dst_lit", ex_dst, 32'd3);
    // sra $4,$2,3
    step(0, 1, 0, 0, r_enc(0, 2, 4, 3, 6'h03), 32'h1234, 32'h80000010);
    chk("sra_op_lit", ex_op, 32'h6);
    chk("sra_in1_lit", ex_in1, 32'h80000010);
    // andi $5,$1,0xFFFF
    step(0, 1, 0, 0, i_enc(6'h0C, 1, 5, 16'hFFFF), 32'h77, 32'h0);
    chk("andi_in2_lit", ex_in2, 32'h0000FFFF);
    // slti $6,$1,-1
    step(0, 1, 0, 0, i_enc(6'h0A, 1, 6, 16'hFFFF), 32'h77, 32'h0);
    chk("slti_in2_lit", ex_in2, 32'hFFFFFFFF);

    // lw $7,-4($1) then 3 stall cycles with a different instruction presented
    lw_i  = i_enc(6'h23, 1, 7, 16'hFFFC);
    nxt_i = r_enc(2, 3, 9, 0, 6'h22);
    step(0, 1, 0, 0, lw_i, 32'h100, 32'h0);
    for (int k = 0; k < 3; k++) step(0, 1, 1, 0, nxt_i, 32'h55, 32'h66);
    chk("stall_in2_lit", ex_in2, 32'hFFFFFFFC);
    chk("stall_mr_lit", ex_mem_read, 32'h1);

    // flush + stall with a valid sw, then normal load
    sw_i = i_enc(6'h2B, 1, 2, 16'h0010);
    step(0, 1, 1, 1, sw_i, 32'h200, 32'hCAFE);
    step(0, 1, 0, 0, sw_i, 32'h200, 32'hCAFE);

    // illegal opcode pulse, then add to $zero
    step(0, 1, 0, 0, {6'h3F, 26'h0}, 32'h1, 32'h2);
    step(0, 1, 0, 0, r_enc(1, 2, 0, 0, 6'h20), 32'h1, 32'h2);
    // illegal then stall: pulse still lasts a single cycle
    step(0, 1, 0, 0, r_enc(1, 2, 3, 0, 6'h26), 32'h1, 32'h2);
    step(0, 1, 1, 0, r_enc(1, 2, 3, 0, 6'h20), 32'h1, 32'h2);
    // reset mid-stall drops the held instruction
    step(0, 1, 0, 0, lw_i, 32'h100, 32'h0);
    step(0, 1, 1, 0, nxt_i, 32'h1, 32'h2);
    step(1, 1, 1, 0, nxt_i, 32'h1, 32'h2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 20), ($urandom_range(0, 99) < 10),
           rand_instr(), $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
ID/EX pipeline stage that drives the ALU input side of the interface: in1, in2, op and shamt.
- Decodes the 32-bit MIPS instruction in ID into the ALU 4-bit op code, operand selection and shift amount.
- Registers the decoded values, plus destination and memory/branch control, for EX on the next clock.
- Supports a pipeline stall (hold) and a flush (bubble insert).

Parameters:
DATA_W, 32, operand/immediate-extended width
REG_AW, 5, register-index width

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
id_valid  in  1  ID holds a real instruction this cycle
id_instr  in  32  instruction word from IF/ID
id_rs_data  in  DATA_W  rs register value (already forwarded)
id_rt_data  in  DATA_W  rt register value (already forwarded)
stall  in  1  hazard unit: hold ID/EX contents
flush  in  1  branch/exception: kill contents
id_ready  out  1  = ~stall; ID may advance
ex_valid  out  1  EX slot holds a real instruction
ex_op  out  4  ALU op code
ex_shamt  out  5  ALU shift amount
ex_in1  out  DATA_W  ALU operand 1
ex_in2  out  DATA_W  ALU operand 2
ex_rt_data  out  DATA_W  store data for sw
ex_dst  out  REG_AW  writeback register index
ex_reg_write  out  1  writeback enable
ex_mem_read  out  1  lw
ex_mem_write  out  1  sw
ex_branch  out  1  beq (EX compares via ALU sub)
ex_illegal  out  1  one-cycle pulse: undecodable instruction captured

Behaviour:
- ALU op codes: ADD=0000, SUB=0001, AND=0010, OR=0011, SLL=0100, SRL=0101, SRA=0110, NOR=0111, SLT=1000. For SLT the ALU computes (in2>in1), so in1=rs and in2=rt/imm gives rs<rt.
- R-type decode (opcode 0x00), by funct:
  - 0x20/0x21 ADD; 0x22/0x23 SUB; 0x24 AND; 0x25 OR; 0x27 NOR; 0x2A SLT.
  - 0x00 SLL, 0x02 SRL, 0x03 SRA.
  - in1=rs, in2=rt, dst=rd, reg_write=1.
  - For shifts: in1=rt, shamt=instr[10:6], in2=rt.
  - For all other ops shamt=0.
- I-type decode, with in1=rs, in2=imm, dst=rt:
  - 0x08/0x09 ADD, sign-extended imm.
  - 0x0A SLT, sign-extended imm.
  - 0x0C AND, zero-extended imm.
  - 0x0D OR, zero-extended imm.
  - 0x23 lw: ADD sign-ext, mem_read=1, reg_write=1.
  - 0x2B sw: ADD sign-ext, mem_write=1, reg_write=0, ex_rt_data=rt.
  - 0x04 beq: SUB, in2=rt, branch=1, reg_write=0.
- dst=0 forces reg_write=0. Writes to $zero are suppressed here.
- Any other opcode/funct is illegal. It loads as a bubble and asserts ex_illegal for exactly one cycle.
- Register update priority each rising clk edge: rst > flush > stall > load.
  - rst: every output register cleared to 0 (ex_op=ADD=0000). ex_valid=0, ex_illegal=0.
  - flush: ex_valid, reg_write, mem_read, mem_write, branch, illegal <= 0. Data fields are don't-care and are cleared to 0.
  - stall (no flush): all registers hold, and ex_illegal is cleared after its pulse.
  - load: when id_valid=1, decoded values are captured. When id_valid=0, a bubble is loaded: all control fields 0, ex_valid=0.
- flush and stall asserted together: flush wins and a bubble is inserted.
- Latency: exactly 1 cycle from ID to EX outputs.
- Control bits are never set while ex_valid=0.
- id_ready is combinational: id_ready=~stall.
- Reset asserted mid-stall clears everything. No held instruction survives reset.

Decomposition:
- Shared package alu_defs_pkg:
  - ALU op code constants (ADD..SLT)
  - opcode/funct constants
  - a packed struct for decoded control (op, shamt, sel_shift, imm_zext, reg_write, mem_read, mem_write, branch, illegal)
- Sub-module alu_op_decode: purely combinational instr -> control struct, reusable by a future hazard unit.
- alu_issue_stage holds the operand mux, extension and the ID/EX register.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0, ex_valid=0, id_ready=1 (stall=0).
- add $3,$1,$2 with rs=5, rt=-7 -> next cycle: ex_op=0000, in1=5, in2=0xFFFFFFF9, dst=3, reg_write=1, ex_valid=1.
- sra $4,$2,3 (rt=0x80000010) -> ex_op=0110, shamt=3, in1=0x80000010, dst=4. Then andi $5,$1,0xFFFF -> ex_op=0010, in2=0x0000FFFF. Then slti $6,$1,-1 -> ex_op=1000, in2=0xFFFFFFFF.
- Stall: load lw $7,-4($1), then stall=1 for 3 cycles with a new instr presented -> outputs held (op=0000, in2=0xFFFFFFFC, mem_read=1, dst=7). id_ready=0 throughout.
- flush+stall in the same cycle with sw valid -> ex_valid=0, mem_write=0 next cycle. Next normal load proceeds.
- Illegal opcode 0x3F -> ex_valid=0, ex_illegal=1 for exactly one cycle, then 0. Also add $0,$1,$2 -> reg_write=0.
